muldiv_ctrl: RTL and testbench

// - Sequencer and HI/LO owner for the multiply/divide unit in the E stage of the 5-stage pipeline.
// - Accepts one md operation per start pulse and models the fixed mult/div latency with a busy countdown.
// - Commits results to HI/LO when the countdown ends.
// - Drives md_stall so the hazard unit holds any HI/LO-class instruction in D until the unit is free.

---
 rtl/muldiv_ctrl_pkg.sv | 26 ++
 rtl/muldiv_ctrl_md_alu.sv | 60 ++++++
 rtl/muldiv_ctrl.sv | 97 +++++++++
 tb/tb_muldiv_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared md_op encodings, FSM state type and op-class helpers for the
// multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_alu.sv
// Combinational 32x32 multiply / 32/32 divide datapath. Result is packed as
// {hi, lo}; divides place the remainder in hi and the quotient in lo.
module md_alu
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic               w_b_zero;
  logic               w_ovf;
  logic [31:0]        w_squot;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  assign w_sprod  = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod  = {32'd0, i_a} * {32'd0, i_b};
  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Divider is guarded so a zero divisor never produces X; the controller
  // suppresses the commit in that case anyway.
  always_comb begin
    w_squot = 32'd0;
    w_srem  = 32'd0;
    w_uquot = 32'd0;
    w_urem  = 32'd0;
    if (!w_b_zero) begin
      w_uquot = i_a / i_b;
      w_urem  = i_a % i_b;
      if (w_ovf) begin
        w_squot = 32'h8000_0000;
        w_srem  = 32'd0;
      end else begin
        w_squot = $signed(i_a) / $signed(i_b);
        w_srem  = $signed(i_a) % $signed(i_b);
      end
    end
  end

  always_comb begin
    o_result = 64'd0;
    case (i_md_op)
      MD_MULT:  o_result = w_sprod;
      MD_MULTU: o_result = w_uprod;
      MD_DIV:   o_result = {w_srem, w_squot};
      MD_DIVU:  o_result = {w_urem, w_uquot};
      default:  o_result = 64'd0;
    endcase
  end

  assign o_div0 = w_b_zero;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy countdown, HI/LO ownership
// and the D-stage stall request for HI/LO-class instructions.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   dbg_state,
  output logic [3:0]  dbg_cnt
);

  localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pending;
  logic        r_div0;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_result;
  logic        w_div0;

  md_alu u_md_alu (
    .i_md_op  (md_op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pending <= 64'd0;
      r_div0    <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_mult(md_op) || is_div(md_op)) begin
              r_pending <= w_result;
              r_div0    <= is_div(md_op) && w_div0;
              r_cnt     <= is_div(md_op) ? LP_DIV_N : LP_MULT_N;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              r_hi <= a;
            end else if (md_op == MD_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_RUN: begin
          // A start arriving here is dropped; the hazard unit never issues one.
          if (r_cnt == 4'd1) begin
            if (!r_div0) begin
              r_hi <= r_pending[63:32];
              r_lo <= r_pending[31:0];
            end
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign md_stall  = d_is_md & (r_busy | start);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed spec cases plus a short
// random run, with a {hi,lo} scoreboard checked when busy falls.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   dbg_state;
  logic [3:0]  dbg_cnt;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_checks;
  int          n_pass;

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .d_is_md   (d_is_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model, written from the arithmetic definitions using 64-bit math.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] chi,
                                        input logic [31:0] clo);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] ux;
    logic [63:0] uy;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    res = {chi, clo};
    case (op)
      MD_MULT:  res = sx * sy;
      MD_MULTU: res = ux * uy;
      MD_DIV: if (y != 0) begin
        q   = sx / sy;
        r   = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      MD_DIVU: if (y != 0) res = {ux[31:0] % y, ux[31:0] / y};
      default: res = {chi, clo};
    endcase
    return res;
  endfunction

  // Issue one mult/div op, follow the busy window, then score {hi,lo}.
  task automatic run_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic stall_d, input logic extra_start);
    int          n;
    int          exp_n;
    logic [63:0] exp;
    exp_n = is_div(op) ? DIV_N : MULT_N;
    exp_q.push_back(model(op, x, y, m_hi, m_lo));
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y; d_is_md = stall_d;
    #1;
    check("stall_start", {63'd0, md_stall}, {63'd0, stall_d});
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE; a = $urandom(); b = $urandom();
    check("busy_rise", {63'd0, busy}, 64'd1);
    n = 0;
    while (busy && n < 40) begin
      if (n == 0 || n == exp_n - 1)
        check("stall_busy", {63'd0, md_stall}, {63'd0, stall_d});
      if (n == exp_n - 1) check("hilo_hold", {hi, lo}, {m_hi, m_lo});
      if (extra_start && n == 2) begin
        start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd3;
      end
      @(posedge clk); #1;
      if (extra_start && n == 2) begin
        start = 1'b0; md_op = MD_NONE;
        check("cnt_ignore", {60'd0, dbg_cnt}, 64'(exp_n - 3));
      end
      n++;
    end
    check("busy_len", 64'(n), 64'(exp_n));
    check("stall_after", {63'd0, md_stall}, 64'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check("hilo_commit", {hi, lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
    d_is_md = 1'b0;
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; d_is_md = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    if (op == MD_MTHI) m_hi = x;
    else m_lo = x;
    check("mt_busy", {63'd0, busy}, 64'd0);
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic run_reset_mid_div();
    int seen;
    @(negedge clk);
    start = 1'b1; md_op = MD_DIVU; a = 32'd1000; b = 32'd3; d_is_md = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_cnt", {60'd0, dbg_cnt}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (DIV_N + 4) begin
      @(posedge clk); #1;
      if (busy) seen++;
    end
    check("rst_no_busy", 64'(seen), 64'd0);
    check("rst_no_commit", {hi, lo}, 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0; n_pass = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_md(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    check("mult_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_md(MD_MULT, 32'd9, 32'd9, 1'b0, 1'b0);
    run_md(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    check("divu_spec", {hi, lo}, {32'd2, 32'd14});
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_mt(MD_MTHI, 32'h0000_1234);
    run_mt(MD_MTLO, 32'd5);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
    run_mt(MD_MTHI, 32'h0000_00AA);
    run_mt(MD_MTLO, 32'h0000_00BB);
    run_md(MD_DIV, 32'd77, 32'd0, 1'b1, 1'b1);
    check("div0_kept", {hi, lo}, {32'hAA, 32'hBB});

    // Random mix, including occasional zero divisors
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom();
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if (is_div(rop) && $urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 300));
      run_md(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    run_reset_mid_div();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
